and_assign: RTL and testbench

AND_ASSIGN -- requirements
Module: and_assign

---
 rtl/and_assign_pkg.sv | 9 +
 rtl/and_assign_sat_counter.sv | 51 +++++
 rtl/and_assign.sv | 50 +++++
 tb/tb_and_assign.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/and_assign_pkg.sv
// Shared constants for the and_assign block.
package and_assign_pkg;

  localparam int unsigned CNT_W_DEF = 8;

  // Truncate to the counter width to get an all-ones value of any legal width.
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/and_assign_sat_counter.sv
// Saturating up-counter with synchronous clear and sticky saturation flag.
module sat_counter
  import and_assign_pkg::*;
#(
  parameter int unsigned W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  localparam logic [W-1:0] MAX = W'(ALL_ONES);

  logic [W-1:0] cnt_d, cnt_q;
  logic         sat_d, sat_q;

  // Next count: clear wins over increment; hold at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else begin
      if (inc && (cnt_q != MAX)) begin
        cnt_d = cnt_q + W'(1);
      end
      if (cnt_d == MAX) begin
        sat_d = 1'b1;
      end
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = sat_q;

endmodule

// File: rtl/and_assign.sv
// Combinational AND with registered copy, edge pulses and a high-cycle counter.
module and_assign
  import and_assign_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
  output logic             y,
  output logic             y_q,
  output logic             y_rise,
  output logic             y_fall,
  output logic [CNT_W-1:0] hi_cnt,
  output logic             hi_sat
);

  logic y_d;

  // Zero-latency AND path, independent of clock and reset.
  assign y = a & b;

  // Registered copy of y and its one-cycle-delayed history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= 1'b0;
      y_d <= 1'b0;
    end else begin
      y_q <= y;
      y_d <= y_q;
    end
  end

  assign y_rise = y_q & ~y_d;
  assign y_fall = ~y_q & y_d;

  sat_counter #(
    .W (CNT_W)
  ) u_sat_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (y),
    .cnt   (hi_cnt),
    .sat   (hi_sat)
  );

endmodule

// File: tb/tb_and_assign.sv
// Directed scoreboard bench for and_assign with a 3-bit counter.
module tb_and_assign;

  localparam int unsigned W = 3;

  logic         clk;
  logic         rst_n;
  logic         a, b, clr;
  logic         y, y_q, y_rise, y_fall, hi_sat;
  logic [W-1:0] hi_cnt;
  logic         clk_run = 1'b0;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct packed {
    logic         yq;
    logic         rise;
    logic         fall;
    logic [W-1:0] cnt;
    logic         sat;
  } exp_t;

  exp_t sb[$];

  // Independent reference state.
  logic         m_yq, m_yd, m_sat;
  logic [W-1:0] m_cnt;

  and_assign #(.CNT_W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .clr    (clr),
    .y      (y),
    .y_q    (y_q),
    .y_rise (y_rise),
    .y_fall (y_fall),
    .hi_cnt (hi_cnt),
    .hi_sat (hi_sat)
  );

  initial begin
    clk = 1'b0;
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_yq  = 1'b0;
    m_yd  = 1'b0;
    m_cnt = '0;
    m_sat = 1'b0;
  endtask

  // Drive one cycle of stimulus, predict, then compare after the edge.
  task automatic step(input logic ia, input logic ib, input logic ic);
    exp_t e;
    exp_t g;
    logic yy;
    @(negedge clk);
    a = ia; b = ib; clr = ic;
    yy   = ia & ib;
    m_yd = m_yq;
    m_yq = yy;
    if (ic) begin
      m_cnt = '0;
      m_sat = 1'b0;
    end else if (yy && m_cnt != 3'd7) begin
      m_cnt = m_cnt + 3'd1;
      if (m_cnt == 3'd7) m_sat = 1'b1;
    end
    e.yq   = m_yq;
    e.rise = m_yq & ~m_yd;
    e.fall = ~m_yq & m_yd;
    e.cnt  = m_cnt;
    e.sat  = m_sat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    n_checks++;
    assert (sb.size() != 0) else begin
      n_fails++;
      $error("FAIL sb_empty observed=%0d expected=%0d", sb.size(), 1);
    end
    if (sb.size() != 0) begin
      g = sb.pop_front();
      chk("y_q",    32'(y_q),    32'(g.yq));
      chk("y_rise", 32'(y_rise), 32'(g.rise));
      chk("y_fall", 32'(y_fall), 32'(g.fall));
      chk("hi_cnt", 32'(hi_cnt), 32'(g.cnt));
      chk("hi_sat", 32'(hi_sat), 32'(g.sat));
      chk("y",      32'(y),      32'(ia & ib));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_y_q"},    32'(y_q),    32'd0);
    chk({tag, "_y_rise"}, 32'(y_rise), 32'd0);
    chk({tag, "_y_fall"}, 32'(y_fall), 32'd0);
    chk({tag, "_hi_cnt"}, 32'(hi_cnt), 32'd0);
    chk({tag, "_hi_sat"}, 32'(hi_sat), 32'd0);
  endtask

  initial begin
    logic [1:0] ab;
    // Truth table with the clock stopped and reset/clear left undriven.
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      a = ab[1];
      b = ab[0];
      #1;
      chk($sformatf("truth_%0d", i), 32'(y), 32'(ab[1] & ab[0]));
      #99;
    end

    // Power-on reset with the clock running.
    rst_n = 1'b0;
    clr   = 1'b0;
    a     = 1'b0;
    b     = 1'b0;
    clk_run = 1'b1;
    model_reset();
    #1;
    chk_all_zero("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Rise then fall pulses.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);

    // Saturation at 7 with sticky flag.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // Clear wins over a simultaneous increment at count 5.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);

    // Asynchronous reset mid-count at 4.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_all_zero("mid_rst");
    chk("mid_rst_y", 32'(y), 32'd1);
    a = 1'b0;
    #1;
    chk("mid_rst_y0", 32'(y), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
